// File: rtl/rotary_value_sched_if.sv
// Shared host update port: one offer at a time, valid/ready handshake.
interface rotary_value_sched_if #(
  parameter int VAL_W = 8
);
  logic             upd_valid;
  logic             upd_chan;
  logic [VAL_W-1:0] upd_value;
  logic             upd_ready;

  modport master (
    output upd_valid,
    output upd_chan,
    output upd_value,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_chan,
    input  upd_value,
    output upd_ready
  );
endinterface

// File: rtl/rotary_value_sched.sv
// Two rotary channels accumulate steps into display values and
// share one round-robin update port toward the host.
module rotary_value_sched #(
  parameter int CNT_W = 4,
  parameter int VAL_W = 8
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic                 left_cw,
  input  logic                 left_ccw,
  input  logic                 right_cw,
  input  logic                 right_ccw,
  input  logic [15:0]          buttons,
  rotary_value_sched_if.master upd,
  output logic [VAL_W-1:0]     hex_left,
  output logic [VAL_W-1:0]     hex_right
);
  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    OFFER
  } state_e;

  localparam logic signed [CNT_W:0] PMAX =
    (CNT_W+1)'(2**(CNT_W-1)-1);
  localparam logic signed [CNT_W:0] PMIN = -PMAX;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic [1:0]            btn_q;
  logic [1:0]            clr_q, clr_d;
  logic [1:0][CNT_W-1:0] pend_q, pend_d;
  logic [1:0][VAL_W-1:0] val_q, val_d;
  logic [1:0][CNT_W-1:0] dlt;
  logic [1:0]            rise, work, cw, ccw;
  logic                  unused_btn;

  assign unused_btn = ^buttons[15:2];
  assign cw   = {right_cw, left_cw};
  assign ccw  = {right_ccw, left_ccw};
  assign rise = buttons[1:0] & ~btn_q;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] p,
    input logic [CNT_W-1:0] d
  );
    logic signed [CNT_W:0] s;
    s = $signed({p[CNT_W-1], p}) + $signed({d[CNT_W-1], d});
    if (s > PMAX) s = PMAX;
    else if (s < PMIN) s = PMIN;
    return s[CNT_W-1:0];
  endfunction

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      dlt[c]  = '0;
      work[c] = (pend_q[c] != '0) || clr_q[c];
      if (cw[c] && !ccw[c]) dlt[c] = CNT_W'(1);
      else if (ccw[c] && !cw[c]) dlt[c] = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    clr_d   = clr_q;
    pend_d  = pend_q;
    val_d   = val_q;
    // a button edge wins over both the step and the APPLY hand-off
    for (int c = 0; c < 2; c++) begin
      if (rise[c]) begin
        pend_d[c] = '0;
        clr_d[c]  = 1'b1;
      end else if (state_q == APPLY && grant_q == 1'(c)) begin
        pend_d[c] = dlt[c];
        clr_d[c]  = 1'b0;
      end else begin
        pend_d[c] = sat_add(pend_q[c], dlt[c]);
      end
    end
    unique case (state_q)
      IDLE: begin
        if (|work) begin
          state_d = APPLY;
          grant_d = (&work) ? ~last_q : work[1];
        end
      end
      APPLY: begin
        state_d = OFFER;
        if (clr_q[grant_q]) begin
          val_d[grant_q] = '0;
        end else begin
          val_d[grant_q] = val_q[grant_q] +
            {{(VAL_W-CNT_W){pend_q[grant_q][CNT_W-1]}},
             pend_q[grant_q]};
        end
      end
      OFFER: begin
        if (upd.upd_ready) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      btn_q   <= '0;
      clr_q   <= '0;
      pend_q  <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      btn_q   <= buttons[1:0];
      clr_q   <= clr_d;
      pend_q  <= pend_d;
      val_q   <= val_d;
    end
  end

  assign upd.upd_valid = (state_q == OFFER);
  assign upd.upd_chan  = grant_q;
  assign upd.upd_value = val_q[grant_q];
  assign hex_left      = val_q[0];
  assign hex_right     = val_q[1];
endmodule
